// File: rtl/maxnet_input_distributor_pkg.sv
// Maxnet-wide shared definitions: lane count, lane numbering and distributor state encoding.
// The distributor and the four-to-one selector both use these lane indices.
package maxnet_input_distributor_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_t;

    localparam lane_t LANE_0 = 2'd0;
    localparam lane_t LANE_1 = 2'd1;
    localparam lane_t LANE_2 = 2'd2;
    localparam lane_t LANE_3 = 2'd3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/maxnet_input_distributor_reg.sv
// WIDTH-bit lane register with async reset, synchronous clear and load enable.
module Register_with_load #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/maxnet_input_distributor.sv
// Steers an in-order word stream into four lane registers and presents them as one set.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_FILL | accepting words; each transfer writes lane `lane` and advances
//   ST_HOLD | all four lanes fresh; out_valid high until out_ack
module maxnet_input_distributor
    import maxnet_input_distributor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       lane,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] out_3,
    output logic [WIDTH-1:0] out_4,
    output logic             out_valid,
    input  logic             out_ack
);

    state_t                        state;
    lane_t                         lane_q;
    logic                          xfer;
    logic [LANES-1:0]              load;
    logic [LANES-1:0][WIDTH-1:0]   lane_data;

    // Handshake outputs come straight off the state register: no path from in_valid/out_ack.
    assign in_ready  = (state == ST_FILL);
    assign out_valid = (state == ST_HOLD);
    assign lane      = lane_q;

    // clear wins over a same-cycle word, so the word is dropped rather than written.
    assign xfer = in_valid && (state == ST_FILL) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FILL;
            lane_q <= LANE_0;
        end else if (clear) begin
            state  <= ST_FILL;
            lane_q <= LANE_0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_valid) begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == LANE_3) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ack) begin
                        state  <= ST_FILL;
                        lane_q <= LANE_0;
                    end
                end
                default: begin
                    state  <= ST_FILL;
                    lane_q <= LANE_0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign load[g] = xfer && (lane_q == LANE_W'(g));

        Register_with_load #(
            .WIDTH (WIDTH)
        ) u_lane_reg (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .load  (load[g]),
            .d     (in_data),
            .q     (lane_data[g])
        );
    end

    assign out_1 = lane_data[0];
    assign out_2 = lane_data[1];
    assign out_3 = lane_data[2];
    assign out_4 = lane_data[3];

endmodule

// File: tb/tb_maxnet_input_distributor.sv
// Self-checking bench for maxnet_input_distributor: directed scenarios plus a randomized run
// checked against a word-count model of the fill/hold behaviour.
module tb_maxnet_input_distributor;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       lane;
    logic [WIDTH-1:0] out_1, out_2, out_3, out_4;
    logic             out_valid;
    logic             out_ack;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: how many words of the current set have been taken (4 = set complete)
    int               m_cnt;
    logic [WIDTH-1:0] m_lane [4];
    logic [WIDTH-1:0] dut_out [4];

    maxnet_input_distributor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lane      (lane),
        .out_1     (out_1),
        .out_2     (out_2),
        .out_3     (out_3),
        .out_4     (out_4),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        dut_out[0] = out_1;
        dut_out[1] = out_2;
        dut_out[2] = out_3;
        dut_out[3] = out_4;
    end

    function automatic void m_reset();
        m_cnt = 0;
        for (int i = 0; i < 4; i++) m_lane[i] = '0;
    endfunction

    // what the coming clock edge must do, given the inputs currently driven
    function automatic void m_step();
        if (clear) begin
            m_reset();
        end else if (m_cnt == 4) begin
            if (out_ack) m_cnt = 0;
        end else if (in_valid) begin
            m_lane[m_cnt] = in_data;
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic logic [1:0] m_exp_lane();
        return (m_cnt == 4) ? 2'd0 : 2'(m_cnt);
    endfunction

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear    = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        m_reset();
        #3;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (lane !== 2'd0)      begin n_err++; $display("FAIL reset_lane got %0d want 0", lane); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_out[i] !== '0) begin n_err++; $display("FAIL reset_out%0d got %h want 0", i + 1, dut_out[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (lane !== 2'd0) begin n_err++; $display("FAIL reset_idle_lane got %0d want 0", lane); end
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words [4];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            tick();
            n_cmp++;
            if (lane !== m_exp_lane()) begin n_err++; $display("FAIL stream_lane[%0d] got %0d want %0d", i, lane, m_exp_lane()); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_out[i] !== words[i]) begin n_err++; $display("FAIL stream_out%0d got %h want %h", i + 1, dut_out[i], words[i]); end
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_out_valid got %0b want 1", out_valid); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL stream_in_ready got %0b want 0", in_ready); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_data  = 32'h55;
        out_ack  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dut_out[i] !== m_lane[i]) begin n_err++; $display("FAIL hold_out%0d got %h want %h", i + 1, dut_out[i], m_lane[i]); end
            end
            n_cmp++; if (lane !== 2'd0)      begin n_err++; $display("FAIL hold_lane got %0d want 0", lane); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_out_valid got %0b want 1", out_valid); end
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL ack_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ack_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_1 !== 32'h11)   begin n_err++; $display("FAIL ack_keeps_out1 got %h want 11", out_1); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_1 !== 32'h55) begin n_err++; $display("FAIL ack_new_word got %h want 55", out_1); end
        n_cmp++; if (lane !== 2'd1)    begin n_err++; $display("FAIL ack_new_lane got %0d want 1", lane); end
        n_cmp++; if (out_2 !== 32'h22) begin n_err++; $display("FAIL ack_keeps_out2 got %h want 22", out_2); end
    endtask

    task automatic test_bubbles();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = $urandom;
            tick();
            n_cmp++;
            if (lane !== m_exp_lane()) begin n_err++; $display("FAIL bubble_lane[%0d] got %0d want %0d", c, lane, m_exp_lane()); end
            n_cmp++;
            if (out_valid !== (c == 6 || c == 7)) begin n_err++; $display("FAIL bubble_out_valid[%0d] got %0b want %0b", c, out_valid, (c == 6 || c == 7)); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_out[i] !== m_lane[i]) begin n_err++; $display("FAIL bubble_out%0d got %h want %h", i + 1, dut_out[i], m_lane[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_clear_midfill();
        out_ack = 1'b1;
        tick();
        out_ack  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        n_cmp++; if (lane !== 2'd2) begin n_err++; $display("FAIL clr_pre_lane got %0d want 2", lane); end
        in_data = 32'hC;
        clear   = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_out[i] !== '0) begin n_err++; $display("FAIL clr_out%0d got %h want 0", i + 1, dut_out[i]); end
        end
        n_cmp++; if (lane !== 2'd0)      begin n_err++; $display("FAIL clr_lane got %0d want 0", lane); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_spurious_ack();
        in_valid = 1'b1;
        in_data  = 32'hD00D;
        tick();
        in_valid = 1'b0;
        out_ack  = 1'b1;
        tick();
        out_ack = 1'b0;
        n_cmp++; if (lane !== 2'd1)        begin n_err++; $display("FAIL sack_lane got %0d want 1", lane); end
        n_cmp++; if (in_ready !== 1'b1)    begin n_err++; $display("FAIL sack_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL sack_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_1 !== 32'hD00D)   begin n_err++; $display("FAIL sack_out1 got %h want d00d", out_1); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_hold got %0b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL arst_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (lane !== 2'd0)      begin n_err++; $display("FAIL arst_lane got %0d want 0", lane); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_out[i] !== '0) begin n_err++; $display("FAIL arst_out%0d got %h want 0", i + 1, dut_out[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            out_ack  = ($urandom_range(0, 9) < 4);
            clear    = ($urandom_range(0, 99) < 3);
            in_data  = $urandom;
            tick();
            n_cmp++;
            if (lane !== m_exp_lane()) begin n_err++; $display("FAIL rnd_lane[%0d] got %0d want %0d", c, lane, m_exp_lane()); end
            n_cmp++;
            if (out_valid !== (m_cnt == 4)) begin n_err++; $display("FAIL rnd_out_valid[%0d] got %0b want %0b", c, out_valid, (m_cnt == 4)); end
            n_cmp++;
            if (in_ready !== (m_cnt != 4)) begin n_err++; $display("FAIL rnd_in_ready[%0d] got %0b want %0b", c, in_ready, (m_cnt != 4)); end
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (dut_out[i] !== m_lane[i]) begin n_err++; $display("FAIL rnd_out%0d[%0d] got %h want %h", i + 1, c, dut_out[i], m_lane[i]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_clear_midfill();
        test_spurious_ack();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
